muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the MP3 single-issue MIPS datapath. Consumes the two register-file read ports (rs on ReadData1, rt on ReadData2) and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency. It holds the architectural HI/LO registers, which the MFHI/MFLO path writes back into the register file. The control unit stalls on `Busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width; also the iteration count.

Ports:
- `Clk`  in  1: clock, positive-edge triggered.
- `Reset`  in  1: synchronous, active-high. Sampled on `Clk` rising edge.
- `Start`  in  1: request an operation. Sampled only in IDLE.
- `Op`  in  2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `OperandA`  in  WIDTH: rs, from ReadData1. Multiplicand or dividend; also the MTHI/MTLO source.
- `OperandB`  in  WIDTH: rt, from ReadData2. Multiplier or divisor.
- `HiWrite`  in  1: MTHI, loads HI from `OperandA`.
- `LoWrite`  in  1: MTLO, loads LO from `OperandA`.
- `Busy`  out  1: an operation is in progress (states RUN and FIX).
- `Done`  out  1: one-cycle pulse when HI/LO have been updated by an operation.
- `Hi`  out  WIDTH: HI register. Holds the upper product or the remainder.
- `Lo`  out  WIDTH: LO register. Holds the lower product or the quotient.
- `DivByZero`  out  1: the last divide had divisor 0. Held until the next accepted `Start`.

## Operation
- States:
  - IDLE: accept `Start`.
  - RUN: WIDTH iterations, one per edge.
  - FIX: sign correction and HI/LO write.
- Accept (IDLE, `Start`=1):
  - Latch magnitudes of both operands. Signed ops use the absolute value; unsigned ops use the raw value.
  - Latch the result sign and the remainder sign.
  - Clear the iteration counter and `DivByZero`.
  - Go to RUN.
- Multiply: shift-add over WIDTH bits into a 2·WIDTH accumulator.
  - Signed result = two's-complement negation of the product when the operand signs differ.
- Divide: restoring division, one quotient bit per iteration.
  - Signed quotient truncates toward zero and is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - −2^(WIDTH−1) / −1 gives LO = 0x80000000, HI = 0. No trap.
- Divisor 0:
  - Iterations run with unchanged latency.
  - FIX writes HI = dividend (raw `OperandA` as latched) and LO = all-ones.
  - FIX sets `DivByZero`=1.
- FIX: writes HI/LO, pulses `Done`, returns to IDLE.
- `HiWrite`/`LoWrite`:
  - Honoured only in IDLE with `Start`=0. Both may fire together.
  - Ignored while `Busy`, or when `Start`=1 (`Start` wins).
  - Do not assert `Done`.
- `Start` while `Busy`: ignored. `Op` and operands are latched only at accept and may change freely afterwards.
- Reset values: `Hi`=0, `Lo`=0, `Busy`=0, `Done`=0, `DivByZero`=0, state IDLE, counter 0.
- `Reset` at any edge, including mid-operation, abandons the operation. It wins over `Start`/`HiWrite`/`LoWrite` on the same edge.

## Timing
- Accept edge E:
  - `Busy`=1 from after E until after edge E+WIDTH+1.
  - RUN iterations occur on edges E+1 … E+WIDTH.
  - FIX occurs on edge E+WIDTH+1.
  - After E+WIDTH+1: `Hi`/`Lo` are valid, `Done`=1 for exactly one cycle, `Busy`=0.
  - With WIDTH=32, the result arrives 33 edges after accept.
- A new `Start` may be accepted on the same edge where `Done` is high (back-to-back). In that case `Done` falls and `Busy` rises after that edge.
- MTHI/MTLO: `Hi`/`Lo` update on the sampling edge. Latency is 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath is not compiled.
  - `Start` with `Op[1]`=1 is ignored: state stays IDLE, no `Busy`, no `Done`, HI/LO unchanged.
  - `DivByZero` is tied to 0.
  - Multiply ops and MTHI/MTLO are unchanged.

## Test plan
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF:
  - Expect `Done` 33 edges after accept.
  - `Hi`=0xFFFFFFFE, `Lo`=0x00000001.
  - `Busy` high exactly 33 cycles.
- MULT, −3 × 5: expect `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFF1.
- Divide results:
  - DIV −7 / 2: expect `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF.
  - DIVU 100 / 7: expect `Lo`=0x0000000E, `Hi`=0x00000002.
  - DIV 0x80000000 / 0xFFFFFFFF: expect `Lo`=0x80000000, `Hi`=0.
- DIVU 5 / 0:
  - Expect `Hi`=5, `Lo`=0xFFFFFFFF, `DivByZero`=1 with `Done`.
  - A following MULTU 2 × 3 clears `DivByZero` and gives `Lo`=6.
- Start a MULTU, then:
  - Pulse `Start` with a different `Op` at iteration 10. It must be ignored.
  - Assert `HiWrite` with `OperandA`=0x1234 mid-run. It must be ignored.
  - Assert `Reset` at iteration 20. Expect `Busy`=0, `Hi`=`Lo`=0, and no `Done`.
- In IDLE, assert `HiWrite` and `LoWrite` together with `OperandA`=0xCAFEF00D:
  - Expect both registers = 0xCAFEF00D one edge later, `Done`=0.
  - Without `MULDIV_DIV_EN`, DIVU 9 / 3 must leave `Busy`=0 and HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise only multiply and MTHI/MTLO exist.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             HiWrite,
   input  logic             LoWrite,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             DivByZero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_next;

   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   operand_q;   // multiplicand (mul) or divisor (div) magnitude
   logic [2*WIDTH-1:0] acc, acc_next, mul_next, product;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   a_mag, b_mag, hi_q, lo_q, hi_res, lo_res;
   logic               neg_res, done_q, signed_op, accept, mt_ok;

`ifdef MULDIV_DIV_EN
   logic               is_div, neg_rem, dbz_q;
   logic [WIDTH-1:0]   raw_a, diff;
   logic [WIDTH:0]     shifted;
   logic [2*WIDTH-1:0] div_next;
`endif

   assign signed_op = ~Op[0];
   assign a_mag = (signed_op && OperandA[WIDTH-1]) ? -OperandA : OperandA;
   assign b_mag = (signed_op && OperandB[WIDTH-1]) ? -OperandB : OperandB;

`ifdef MULDIV_DIV_EN
   assign accept = (state == IDLE) && Start;
`else
   assign accept = (state == IDLE) && Start && !Op[1];
`endif
   // Start wins over MTHI/MTLO even when the requested op is not built.
   assign mt_ok = (state == IDLE) && !Start;

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (count == LAST) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      Busy = (state == RUN) || (state == FIX);
   end

   // Shift-add: add the multiplicand into the upper half when the current multiplier bit is set.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & operand_q};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};
   assign product  = neg_res ? -acc : acc;

`ifdef MULDIV_DIV_EN
   // Restoring step: upper half is the partial remainder, lower half shifts dividend out and quotient in.
   assign shifted  = acc[2*WIDTH-1:WIDTH-1];
   assign diff     = shifted[WIDTH-1:0] - operand_q;
   assign div_next = (shifted >= {1'b0, operand_q}) ? {diff, acc[WIDTH-2:0], 1'b1}
                                                    : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   assign acc_next = is_div ? div_next : mul_next;
`else
   assign acc_next = mul_next;
`endif

   always_comb begin
      hi_res = product[2*WIDTH-1:WIDTH];
      lo_res = product[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         if (operand_q == '0) begin
            hi_res = raw_a;
            lo_res = '1;
         end else begin
            hi_res = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_res = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         end
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count     <= '0;
         operand_q <= '0;
         acc       <= '0;
         neg_res   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div    <= 1'b0;
         neg_rem   <= 1'b0;
         dbz_q     <= 1'b0;
         raw_a     <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  count   <= '0;
                  neg_res <= signed_op && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                  is_div    <= Op[1];
                  neg_rem   <= signed_op && Op[1] && OperandA[WIDTH-1];
                  raw_a     <= OperandA;
                  dbz_q     <= 1'b0;
                  operand_q <= Op[1] ? b_mag : a_mag;
                  acc       <= {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
`else
                  operand_q <= a_mag;
                  acc       <= {{WIDTH{1'b0}}, b_mag};
`endif
               end else if (mt_ok) begin
                  if (HiWrite) hi_q <= OperandA;
                  if (LoWrite) lo_q <= OperandA;
               end
            end
            RUN: begin
               acc   <= acc_next;
               count <= count + 1'b1;
            end
            FIX: begin
               hi_q   <= hi_res;
               lo_q   <= lo_res;
               done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
               dbz_q  <= is_div && (operand_q == '0);
`endif
            end
            default: ;
         endcase
      end
   end

   assign Hi   = hi_q;
   assign Lo   = lo_q;
   assign Done = done_q;
`ifdef MULDIV_DIV_EN
   assign DivByZero = dbz_q;
`else
   assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO come from a behavioural model via a scoreboard queue.
// Divide checks follow MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         Clk, Reset, Start, HiWrite, LoWrite;
   logic [1:0]   Op;
   logic [W-1:0] OperandA, OperandB;
   logic         Busy, Done, DivByZero;
   logic [W-1:0] Hi, Lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } res_t;

   res_t         scoreboard[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] hi_exp, lo_exp;
   logic [1:0]   rop;
   bit           done_seen;

   muldiv_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
      .OperandA(OperandA), .OperandB(OperandB),
      .HiWrite(HiWrite), .LoWrite(LoWrite),
      .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t        r;
      longint      sa, sbv, q, m;
      logic [63:0] p;
      r.dbz = 1'b0;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         2'b00: p = 64'(sa * sbv);
         2'b01: p = {32'b0, a} * {32'b0, b};
         default: begin
            if (b == 0) begin
               p = {a, 32'hFFFF_FFFF};
               r.dbz = 1'b1;
            end else begin
               if (op == 2'b10) begin
                  q = sa / sbv;
                  m = sa % sbv;
               end else begin
                  q = longint'(a) / longint'(b);
                  m = longint'(a) % longint'(b);
               end
               p = {m[31:0], q[31:0]};
            end
         end
      endcase
      r.hi = p[63:32];
      r.lo = p[31:0];
      return r;
   endfunction

   // Issue one op, watch Busy until Done, then compare against the scoreboard head.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb);
      res_t e;
      int   edges, busy_cycles;
      scoreboard.push_back(model(op, a, b));
      Start = 1'b1; Op = op; OperandA = a; OperandB = b;
      step();
      Start = 1'b0; Op = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
      check("busy_after_accept", Busy, 1);
      check("done_low_after_accept", Done, 0);
      edges = 0;
      busy_cycles = 0;
      while (!Done && edges < 40) begin
         if (Busy) busy_cycles++;
         if (disturb && edges == 10) begin
            Start = 1'b1; Op = op ^ 2'b01; OperandA = 32'd77; OperandB = 32'd11;
         end
         if (disturb && edges == 12) begin
            HiWrite = 1'b1; LoWrite = 1'b1; OperandA = 32'h1234;
         end
         if (disturb && edges == 15) check("mt_ignored_busy_hi", Hi, hi_exp);
         step();
         edges++;
         Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      end
      check("latency_edges", edges, W + 1);
      check("busy_cycles", busy_cycles, W + 1);
      check("done_pulse", Done, 1);
      check("busy_low_at_done", Busy, 0);
      e = scoreboard.pop_front();
      check("hi", Hi, e.hi);
      check("lo", Lo, e.lo);
      check("div_by_zero", DivByZero, e.dbz);
      hi_exp = e.hi;
      lo_exp = e.lo;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
      HiWrite = 1'b0; LoWrite = 1'b0;
      step();
      // Reset must win over Start and MTHI on the same edge.
      Start = 1'b1; HiWrite = 1'b1; OperandA = 32'hFFFF;
      step();
      Reset = 1'b0; Start = 1'b0; HiWrite = 1'b0;
      check("reset_hi", Hi, 0);
      check("reset_lo", Lo, 0);
      check("reset_busy", Busy, 0);
      check("reset_done", Done, 0);
      check("reset_dbz", DivByZero, 0);
      hi_exp = '0;
      lo_exp = '0;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max_hi_const", Hi, 32'hFFFF_FFFE);
      check("multu_max_lo_const", Lo, 32'h0000_0001);
      run_op(2'b00, -32'sd3, 32'sd5, 1'b0);
      check("mult_neg_lo_const", Lo, 32'hFFFF_FFF1);

`ifdef MULDIV_DIV_EN
      run_op(2'b10, -32'sd7, 32'sd2, 1'b0);
      check("div_neg_lo_const", Lo, 32'hFFFF_FFFD);
      check("div_neg_hi_const", Hi, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd100, 32'd7, 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf_lo_const", Lo, 32'h8000_0000);
      run_op(2'b11, 32'd5, 32'd0, 1'b0);
      run_op(2'b10, -32'sd9, 32'd0, 1'b0);
      run_op(2'b11, 32'd9, 32'd3, 1'b0);
`endif
      run_op(2'b01, 32'd2, 32'd3, 1'b0);
      check("multu_small_lo_const", Lo, 32'd6);

      for (int i = 0; i < 4; i++) begin
`ifdef MULDIV_DIV_EN
         rop = 2'(i);
`else
         rop = 2'(i % 2);
`endif
         run_op(rop, $urandom, $urandom >> (i * 8), 1'b0);
      end

      run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      step();
      check("done_one_cycle", Done, 0);
      check("idle_after_done", Busy, 0);

      // Reset mid-run abandons the operation.
      Start = 1'b1; Op = 2'b01; OperandA = 32'hDEAD_BEEF; OperandB = 32'h0000_1357;
      step();
      Start = 1'b0;
      repeat (20) step();
      check("busy_mid_run", Busy, 1);
      Reset = 1'b1; Start = 1'b1; HiWrite = 1'b1; OperandA = 32'h1234;
      step();
      Reset = 1'b0; Start = 1'b0; HiWrite = 1'b0;
      check("abort_busy", Busy, 0);
      check("abort_hi", Hi, 0);
      check("abort_lo", Lo, 0);
      check("abort_done", Done, 0);
      hi_exp = '0;
      lo_exp = '0;
      done_seen = 1'b0;
      repeat (40) begin
         step();
         if (Done) done_seen = 1'b1;
      end
      check("no_done_after_abort", done_seen, 0);

      HiWrite = 1'b1; LoWrite = 1'b1; OperandA = 32'hCAFE_F00D;
      step();
      HiWrite = 1'b0; LoWrite = 1'b0;
      check("mthi", Hi, 32'hCAFE_F00D);
      check("mtlo", Lo, 32'hCAFE_F00D);
      check("mt_no_done", Done, 0);
      hi_exp = 32'hCAFE_F00D;
      lo_exp = 32'hCAFE_F00D;

      LoWrite = 1'b1; OperandA = 32'h0BAD_CAFE;
      step();
      LoWrite = 1'b0;
      check("mtlo_only_hi", Hi, hi_exp);
      check("mtlo_only_lo", Lo, 32'h0BAD_CAFE);
      lo_exp = 32'h0BAD_CAFE;

`ifndef MULDIV_DIV_EN
      Start = 1'b1; Op = 2'b11; OperandA = 32'd9; OperandB = 32'd3;
      step();
      Start = 1'b0;
      check("nodiv_busy", Busy, 0);
      check("nodiv_hi", Hi, hi_exp);
      check("nodiv_lo", Lo, lo_exp);
      step();
      check("nodiv_done", Done, 0);
      check("nodiv_busy_later", Busy, 0);
      check("nodiv_dbz", DivByZero, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
